mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter WIDTH, default 32, data and address width of every bus.
REQ-002 Parameter LENW, default 5, burst-length field width (max burst 16).
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 cpu_req  input  1  CPU data-segment access request, held until not stalled.
REQ-006 cpu_we, cpu_addr, cpu_wd  input  1/WIDTH/WIDTH  CPU write enable, byte address and write data.
REQ-007 cpu_stall  output  1  CPU access not served this cycle.
REQ-008 cpu_rd  output  WIDTH  CPU read data, valid in the same cycle as the served request.
REQ-009 io_req  input  1  IO burst start; sampled only in IDLE.
REQ-010 io_we, io_base, io_len  input  1/WIDTH/LENW  burst direction, start address and beat count.
REQ-011 io_wd  input  WIDTH  current IO write word.
REQ-012 io_wd_pop  output  1  io_wd consumed this cycle.
REQ-013 io_rd_valid, io_rd  output  1/WIDTH  IO read beat strobe and data.
REQ-014 io_done, io_err  output  1/1  one-cycle burst completion pulse and error flag (err valid only with done).
REQ-015 m_we, m_addr, m_wd  output  1/WIDTH/WIDTH  shared data port toward the segmented memory.
REQ-016 m_rd  input  WIDTH  memory read data; combinational on m_addr.

Function
REQ-017 The block SHALL implement states IDLE, BURST and DONE.
REQ-018 IDLE with io_req=1: latch io_we, io_base and io_len; clear the beat counter; go to DONE if io_len=0, else to BURST.
REQ-019 Owner per cycle: BURST with (cpu_req=0 or streak=3) -> IO; otherwise CPU if cpu_req=1; otherwise none.
REQ-020 CPU ownership: drive m_addr=cpu_addr, m_we=cpu_we, m_wd=cpu_wd, cpu_rd=m_rd; set cpu_stall=0.
REQ-021 In BURST, a served CPU cycle increments streak, saturating at 3; an IO beat clears streak to 0; streak is 0 outside BURST.
REQ-022 IO beat address SHALL be base + 4*beat, computed modulo 2^WIDTH.
REQ-023 IO beat with address < 1568: drive m_addr/m_we=latched we/m_wd=io_wd; pulse io_wd_pop on writes; pulse io_rd_valid with io_rd=m_rd on reads; increment beat.
REQ-024 The beat with beat = len-1 SHALL transition BURST -> DONE.
REQ-025 IO beat address >= 1568 (includes startIO location): no memory access, m_we=0, set io_err, go to DONE.
REQ-026 DONE lasts exactly one cycle: io_done=1, io_err as latched, then IDLE; CPU is served normally in DONE.
REQ-027 cpu_stall = cpu_req AND owner != CPU, combinational.
REQ-028 io_req in BURST or DONE SHALL be ignored; no queueing.
REQ-029 No owner: m_we=0 and m_addr=0.
REQ-030 m_we SHALL never be 1 for more than one requester in a cycle.

Reset
REQ-031 rst_n=0: state IDLE, beat=0, streak=0, latched fields 0, io_err=0, regardless of clk.
REQ-032 Reset mid-burst SHALL abort silently: no io_done pulse, no further beats.
REQ-033 During reset, registered and IO outputs are 0; cpu_stall follows REQ-027 with owner none.

Structure
REQ-034 Package mem_pkg: state enum, MEM_TOP=1568, STARTIO_ADDR=1568, STREAK_MAX=3.
REQ-035 The block SHALL be a single module with no sub-modules; its memory side connects to the data port of the segmented memory.

Verification
REQ-036 CPU-only: cpu_req=1, we=0, addr=40, m_rd=0x1234 -> cpu_stall=0, cpu_rd=0x1234, m_addr=40 in the same cycle.
REQ-037 IO read burst: base=64, len=3, cpu idle -> m_addr=64, 68, 72 on consecutive cycles; 3 io_rd_valid pulses; io_done on the 4th cycle; io_err=0.
REQ-038 Contention: burst len=2 with cpu_req held high -> 3 CPU cycles, 1 IO beat, 3 CPU cycles, 1 IO beat; cpu_stall=1 exactly on IO beats.
REQ-039 Bounds: base=1564, len=4, write -> one pop and write at 1564; no access at 1568; io_done=1 with io_err=1.
REQ-040 Zero length / reset: io_len=0 -> io_done next cycle with no m_we; rst_n low mid-burst -> IDLE, no io_done, m_we=0.

Source files
------------

// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_pkg
//  Description : Shared types and constants for the memory arbiter
//                (FSM state encoding, memory map limits, fairness limit).
//  Revision    : 1.0  initial release
// ============================================================================
package mem_pkg;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // First address past the data segment of the segmented memory
    localparam int MEM_TOP      = 1568;
    // Memory-mapped startIO trigger; sits exactly at the top of the data segment
    localparam int STARTIO_ADDR = 1568;
    // Consecutive CPU grants allowed during a burst before IO is forced in
    localparam int STREAK_MAX   = 3;

endpackage
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter
//  Description : Shares the single data port of the segmented memory between
//                CPU data accesses and IO bursts. The CPU normally wins, but
//                an IO beat is forced in after three consecutive CPU grants
//                so a busy CPU cannot starve a running burst.
//  Revision    : 1.0  initial release
// ============================================================================
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int LENW  = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    // CPU data-segment port
    input  logic             cpu_req,
    input  logic             cpu_we,
    input  logic [WIDTH-1:0] cpu_addr,
    input  logic [WIDTH-1:0] cpu_wd,
    output logic             cpu_stall,
    output logic [WIDTH-1:0] cpu_rd,
    // IO burst port
    input  logic             io_req,
    input  logic             io_we,
    input  logic [WIDTH-1:0] io_base,
    input  logic [LENW-1:0]  io_len,
    input  logic [WIDTH-1:0] io_wd,
    output logic             io_wd_pop,
    output logic             io_rd_valid,
    output logic [WIDTH-1:0] io_rd,
    output logic             io_done,
    output logic             io_err,
    // Shared memory data port
    output logic             m_we,
    output logic [WIDTH-1:0] m_addr,
    output logic [WIDTH-1:0] m_wd,
    input  logic [WIDTH-1:0] m_rd
);

    localparam logic [LENW-1:0] c_len_one    = {{(LENW-1){1'b0}}, 1'b1};
    localparam logic [1:0]      c_streak_max = 2'(STREAK_MAX);
    localparam logic [WIDTH-1:0] c_mem_top   = WIDTH'(MEM_TOP);
    localparam logic [WIDTH-1:0] c_startio   = WIDTH'(STARTIO_ADDR);

    state_t            r_state, w_state_nx;
    logic [LENW-1:0]   r_beat,   w_beat_nx;
    logic [1:0]        r_streak, w_streak_nx;
    logic              r_we,     w_we_nx;
    logic [WIDTH-1:0]  r_base,   w_base_nx;
    logic [LENW-1:0]   r_len,    w_len_nx;
    logic              r_err,    w_err_nx;

    logic              w_io_own;
    logic              w_cpu_own;
    logic [WIDTH-1:0]  w_beat_addr;
    logic              w_oob;

    // Ownership, beat address and bounds decode
    always_comb begin
        w_io_own    = (r_state == ST_BURST) && (!cpu_req || (r_streak == c_streak_max));
        // Held in reset the CPU owns nothing, so it sees a stall
        w_cpu_own   = rst_n && cpu_req && !w_io_own;
        // Address wraps modulo 2^WIDTH by construction of the adder width
        w_beat_addr = r_base + ({{(WIDTH-LENW){1'b0}}, r_beat} << 2);
        // startIO lies at the segment top, so it is rejected along with the rest
        w_oob       = (w_beat_addr >= c_mem_top) || (w_beat_addr == c_startio);
        cpu_stall   = cpu_req && !w_cpu_own;
        io_done     = (r_state == ST_DONE);
        io_err      = (r_state == ST_DONE) && r_err;
    end

    // Memory port steering and next-state logic
    always_comb begin
        w_state_nx  = r_state;
        w_beat_nx   = r_beat;
        w_streak_nx = r_streak;
        w_we_nx     = r_we;
        w_base_nx   = r_base;
        w_len_nx    = r_len;
        w_err_nx    = r_err;
        m_we        = 1'b0;
        m_addr      = '0;
        m_wd        = '0;
        cpu_rd      = '0;
        io_wd_pop   = 1'b0;
        io_rd_valid = 1'b0;
        io_rd       = '0;

        if (w_cpu_own) begin
            m_addr = cpu_addr;
            m_we   = cpu_we;
            m_wd   = cpu_wd;
            cpu_rd = m_rd;
        end else if (w_io_own && !w_oob) begin
            m_addr      = w_beat_addr;
            m_we        = r_we;
            m_wd        = io_wd;
            io_wd_pop   = r_we;
            io_rd_valid = !r_we;
            io_rd       = m_rd;
        end

        case (r_state)
            ST_IDLE: begin
                w_streak_nx = 2'd0;
                if (io_req) begin
                    w_we_nx    = io_we;
                    w_base_nx  = io_base;
                    w_len_nx   = io_len;
                    w_beat_nx  = '0;
                    w_err_nx   = 1'b0;
                    w_state_nx = (io_len == '0) ? ST_DONE : ST_BURST;
                end
            end
            ST_BURST: begin
                if (w_io_own) begin
                    w_streak_nx = 2'd0;
                    if (w_oob) begin
                        w_err_nx   = 1'b1;
                        w_state_nx = ST_DONE;
                    end else begin
                        w_beat_nx = r_beat + c_len_one;
                        if (r_beat == (r_len - c_len_one)) begin
                            w_state_nx = ST_DONE;
                        end
                    end
                end else if (w_cpu_own && (r_streak != c_streak_max)) begin
                    w_streak_nx = r_streak + 2'd1;
                end
            end
            ST_DONE: begin
                w_streak_nx = 2'd0;
                w_state_nx  = ST_IDLE;
            end
            default: begin
                w_streak_nx = 2'd0;
                w_state_nx  = ST_IDLE;
            end
        endcase
    end

    // State and burst context registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_beat   <= '0;
            r_streak <= 2'd0;
            r_we     <= 1'b0;
            r_base   <= '0;
            r_len    <= '0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_beat   <= w_beat_nx;
            r_streak <= w_streak_nx;
            r_we     <= w_we_nx;
            r_base   <= w_base_nx;
            r_len    <= w_len_nx;
            r_err    <= w_err_nx;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_arbiter
//  Description : Directed bench for mem_arbiter: CPU-only vector table plus
//                hand-written burst, contention, bounds, zero-length and
//                mid-burst reset sequences.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        cpu_req, cpu_we;
    logic [31:0] cpu_addr, cpu_wd;
    logic        cpu_stall;
    logic [31:0] cpu_rd;
    logic        io_req, io_we;
    logic [31:0] io_base;
    logic [4:0]  io_len;
    logic [31:0] io_wd;
    logic        io_wd_pop, io_rd_valid;
    logic [31:0] io_rd;
    logic        io_done, io_err;
    logic        m_we;
    logic [31:0] m_addr, m_wd, m_rd;

    logic        use_model;
    logic [31:0] mrd_force;

    int total = 0;
    int bad   = 0;

    // Memory read model: fixed value for table vectors, address-derived otherwise
    assign m_rd = use_model ? (m_addr + 32'h1000_0000) : mrd_force;

    mem_arbiter #(.WIDTH(32), .LENW(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wd(cpu_wd),
        .cpu_stall(cpu_stall), .cpu_rd(cpu_rd),
        .io_req(io_req), .io_we(io_we), .io_base(io_base), .io_len(io_len),
        .io_wd(io_wd), .io_wd_pop(io_wd_pop), .io_rd_valid(io_rd_valid), .io_rd(io_rd),
        .io_done(io_done), .io_err(io_err),
        .m_we(m_we), .m_addr(m_addr), .m_wd(m_wd), .m_rd(m_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        req;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] mrd;
        logic        e_stall;
        logic [31:0] e_rd;
        logic [31:0] e_addr;
        logic        e_we;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Move to just after the next rising edge, where inputs are changed
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Move to the falling edge, where outputs are sampled
    task automatic sample();
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'd40; cpu_wd = 32'h99;
        io_req = 1'b0; io_we = 1'b0; io_base = '0; io_len = '0; io_wd = '0;
        use_model = 1'b0; mrd_force = 32'h1234;

        vecs[0] = '{1'b1, 1'b0, 32'd40,        32'h0,    32'h1234, 1'b0, 32'h1234, 32'd40,        1'b0};
        vecs[1] = '{1'b1, 1'b1, 32'h80,        32'hDEAD, 32'h5555, 1'b0, 32'h5555, 32'h80,        1'b1};
        vecs[2] = '{1'b0, 1'b1, 32'h80,        32'hDEAD, 32'h0077, 1'b0, 32'h0,    32'h0,         1'b0};
        vecs[3] = '{1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0,    32'hABCD, 1'b0, 32'hABCD, 32'hFFFF_FFFC, 1'b0};
        vecs[4] = '{1'b1, 1'b1, 32'd2000,      32'h4242, 32'h0001, 1'b0, 32'h0001, 32'd2000,      1'b1};

        // Reset: no owner, so a pending CPU request is stalled and the port is idle
        #2;
        chk("rst_stall",  {31'd0, cpu_stall}, 32'd1);
        chk("rst_m_we",   {31'd0, m_we},      32'd0);
        chk("rst_m_addr", m_addr,             32'd0);
        chk("rst_done",   {31'd0, io_done},   32'd0);
        chk("rst_cpu_rd", cpu_rd,             32'd0);
        step();
        rst_n = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0;

        // CPU-only vector table
        for (int i = 0; i < 5; i++) begin
            step();
            cpu_req = vecs[i].req; cpu_we = vecs[i].we; cpu_addr = vecs[i].addr;
            cpu_wd = vecs[i].wd; mrd_force = vecs[i].mrd;
            sample();
            chk($sformatf("vec%0d_stall", i),  {31'd0, cpu_stall}, {31'd0, vecs[i].e_stall});
            chk($sformatf("vec%0d_cpu_rd", i), cpu_rd,             vecs[i].e_rd);
            chk($sformatf("vec%0d_m_addr", i), m_addr,             vecs[i].e_addr);
            chk($sformatf("vec%0d_m_we", i),   {31'd0, m_we},      {31'd0, vecs[i].e_we});
            if (vecs[i].e_we) chk($sformatf("vec%0d_m_wd", i), m_wd, vecs[i].wd);
        end

        // IO read burst, CPU idle; a stray io_req mid-burst must be ignored
        step();
        cpu_req = 1'b0; cpu_we = 1'b0; use_model = 1'b1;
        io_req = 1'b1; io_we = 1'b0; io_base = 32'd64; io_len = 5'd3;
        sample();
        chk("rb_idle_valid", {31'd0, io_rd_valid}, 32'd0);
        for (int b = 0; b < 3; b++) begin
            step();
            io_req = (b == 1); io_len = 5'd1;
            sample();
            chk($sformatf("rb%0d_addr", b),  m_addr,                32'd64 + 32'(4 * b));
            chk($sformatf("rb%0d_valid", b), {31'd0, io_rd_valid}, 32'd1);
            chk($sformatf("rb%0d_data", b),  io_rd,                 32'd64 + 32'(4 * b) + 32'h1000_0000);
            chk($sformatf("rb%0d_m_we", b),  {31'd0, m_we},        32'd0);
            chk($sformatf("rb%0d_done", b),  {31'd0, io_done},     32'd0);
        end
        step();
        io_req = 1'b0;
        sample();
        chk("rb_done", {31'd0, io_done}, 32'd1);
        chk("rb_err",  {31'd0, io_err},  32'd0);
        step();
        sample();
        chk("rb_after_done", {31'd0, io_done}, 32'd0);

        // Contention: CPU writes continuously while a 2-beat IO write runs
        step();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'd100; cpu_wd = 32'h1111;
        io_req = 1'b1; io_we = 1'b1; io_base = 32'd200; io_len = 5'd2; io_wd = 32'hCAFE;
        sample();
        chk("ct_idle_stall", {31'd0, cpu_stall}, 32'd0);
        begin
            logic [7:0] io_slots;
            int k;
            io_slots = 8'b1000_1000;
            k = 0;
            for (int c = 0; c < 8; c++) begin
                step();
                io_req = 1'b0;
                sample();
                chk($sformatf("ct%0d_stall", c), {31'd0, cpu_stall}, {31'd0, io_slots[c]});
                chk($sformatf("ct%0d_pop", c),   {31'd0, io_wd_pop}, {31'd0, io_slots[c]});
                if (io_slots[c]) begin
                    chk($sformatf("ct%0d_addr", c), m_addr, 32'd200 + 32'(4 * k));
                    chk($sformatf("ct%0d_wd", c),   m_wd,   32'hCAFE);
                    k++;
                end else begin
                    chk($sformatf("ct%0d_addr", c), m_addr, 32'd100);
                    chk($sformatf("ct%0d_wd", c),   m_wd,   32'h1111);
                end
            end
        end
        step();
        sample();
        chk("ct_done",       {31'd0, io_done},   32'd1);
        chk("ct_done_stall", {31'd0, cpu_stall}, 32'd0);
        chk("ct_done_addr",  m_addr,             32'd100);

        // Bounds: burst crosses into the startIO location
        step();
        cpu_req = 1'b0; cpu_we = 1'b0;
        io_req = 1'b1; io_we = 1'b1; io_base = 32'd1564; io_len = 5'd4; io_wd = 32'hBEEF;
        sample();
        step();
        io_req = 1'b0;
        sample();
        chk("bd0_m_we", {31'd0, m_we},      32'd1);
        chk("bd0_addr", m_addr,             32'd1564);
        chk("bd0_pop",  {31'd0, io_wd_pop}, 32'd1);
        chk("bd0_wd",   m_wd,               32'hBEEF);
        step();
        sample();
        chk("bd1_m_we", {31'd0, m_we},      32'd0);
        chk("bd1_pop",  {31'd0, io_wd_pop}, 32'd0);
        chk("bd1_done", {31'd0, io_done},   32'd0);
        step();
        sample();
        chk("bd_done", {31'd0, io_done}, 32'd1);
        chk("bd_err",  {31'd0, io_err},  32'd1);
        step();
        sample();
        chk("bd_after", {31'd0, io_done}, 32'd0);

        // Zero length: done on the next cycle, error from the last burst cleared
        step();
        io_req = 1'b1; io_we = 1'b1; io_base = 32'd8; io_len = 5'd0;
        sample();
        step();
        io_req = 1'b0;
        sample();
        chk("zl_done", {31'd0, io_done}, 32'd1);
        chk("zl_m_we", {31'd0, m_we},    32'd0);
        chk("zl_err",  {31'd0, io_err},  32'd0);

        // Reset mid-burst: silent abort
        step();
        io_req = 1'b1; io_we = 1'b1; io_base = 32'd0; io_len = 5'd8; io_wd = 32'h5A5A;
        sample();
        step();
        io_req = 1'b0;
        sample();
        chk("rm_beat_we", {31'd0, m_we}, 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rm_m_we",   {31'd0, m_we},      32'd0);
        chk("rm_pop",    {31'd0, io_wd_pop}, 32'd0);
        chk("rm_m_addr", m_addr,             32'd0);
        chk("rm_done",   {31'd0, io_done},   32'd0);
        step();
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            sample();
            chk($sformatf("rm_post%0d", c), {29'd0, io_done, m_we, io_wd_pop}, 32'd0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
